// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Tracks serial shifts in a frame counter that wraps after WIDTH shifts and
// emits a registered one-cycle frame_done pulse when a frame completes.
module shift_reg_univ #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] pdata,
    output logic             so_r,
    output logic             so_l,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             frame_done
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;

    // Count value at which a frame is complete, and the one just before it.
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic is_shift;

    // A shift is either direction with the block enabled; both advance the frame.
    assign is_shift = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));

    // Register, frame counter and completion pulse all live in one process.
    always_ff @(posedge clk) begin
        if (reset) begin
            q          <= '0;
            count      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_RIGHT: q <= {si_r, q[WIDTH-1:1]};
                    MODE_LEFT:  q <= {q[WIDTH-2:0], si_l};
                    MODE_LOAD:  q <= pdata;
                    MODE_HOLD:  q <= q;
                    default:    q <= q;
                endcase
            end
            if (is_shift) begin
                // A shift on a full count starts the next frame at 1.
                if (count == CNT_MAX) begin
                    count <= CW'(1);
                end else begin
                    count <= count + CW'(1);
                end
                frame_done <= (count == CNT_LAST);
            end else if (en && (mode == MODE_LOAD)) begin
                count <= '0;
            end
        end
    end

    // Serial outputs and full flag are pure decodes of registered state.
    assign so_r = q[0];
    assign so_l = q[WIDTH-1];
    assign full = (count == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=4). The driver applies one vector
// per cycle and queues the hand-computed post-edge state; a monitor pops and
// compares on each falling edge.
module tb_shift_reg_univ;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0]  q;
        logic [CW-1:0] count;
        logic          fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic          si_r;
    logic          si_l;
    logic [W-1:0]  pdata;
    logic          so_r;
    logic          so_l;
    logic [W-1:0]  q;
    logic [CW-1:0] count;
    logic          full;
    logic          frame_done;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .si_r       (si_r),
        .si_l       (si_l),
        .pdata      (pdata),
        .so_r       (so_r),
        .so_l       (so_l),
        .q          (q),
        .count      (count),
        .full       (full),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, idx, act, req);
        end
    endtask

    // Monitor: every falling edge, compare DUT state against the oldest expectation.
    initial begin
        int idx;
        exp_t e;
        idx = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q",          idx, 8'(q),          8'(e.q));
                chk("count",      idx, 8'(count),      8'(e.count));
                chk("frame_done", idx, 8'(frame_done), 8'(e.fd));
                chk("full",       idx, 8'(full),       8'(e.count == CW'(W)));
                chk("so_r",       idx, 8'(so_r),       8'(e.q[0]));
                chk("so_l",       idx, 8'(so_l),       8'(e.q[W-1]));
                idx++;
            end
        end
    end

    // Drive one vector, clock it in, queue the expected resulting state.
    task automatic step(input logic rst, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [W-1:0] pd,
                        input logic [W-1:0] eq, input int ec, input logic efd);
        exp_t x;
        @(negedge clk);
        reset = rst; en = e; mode = m; si_r = sr; si_l = sl; pdata = pd;
        @(posedge clk);
        x.q = eq; x.count = CW'(ec); x.fd = efd;
        exp_q.push_back(x);
        step_no++;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b00; si_r = 1'b0; si_l = 1'b0; pdata = '0;

        // Reset state
        step(1, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Scenario 1: right shift 1,0,1,1
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1000, 1, 0);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0100, 2, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1010, 3, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1101, 4, 1);

        // Scenario 2: right shift zeros, wrap to a second frame
        step(0, 1, 2'b01, 0, 1, 4'b0000, 4'b0110, 1, 0);
        step(0, 1, 2'b01, 0, 1, 4'b0000, 4'b0011, 2, 0);
        step(0, 1, 2'b01, 0, 1, 4'b0000, 4'b0001, 3, 0);
        step(0, 1, 2'b01, 0, 1, 4'b0000, 4'b0000, 4, 1);

        // Hold with enable high: serial inputs ignored, full stays up
        step(0, 1, 2'b00, 1, 1, 4'b1111, 4'b0000, 4, 0);

        // Scenario 3: load 1010 then left shift zeros
        step(0, 1, 2'b11, 1, 1, 4'b1010, 4'b1010, 0, 0);
        step(0, 1, 2'b10, 1, 0, 4'b0000, 4'b0100, 1, 0);
        step(0, 1, 2'b10, 1, 0, 4'b0000, 4'b1000, 2, 0);
        step(0, 1, 2'b10, 1, 0, 4'b0000, 4'b0000, 3, 0);
        step(0, 1, 2'b10, 1, 0, 4'b0000, 4'b0000, 4, 1);

        // Scenario 4: reach q=0110 count=2, then disabled cycles
        step(0, 1, 2'b11, 0, 0, 4'b0001, 4'b0001, 0, 0);
        step(0, 1, 2'b10, 0, 1, 4'b0000, 4'b0011, 1, 0);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b0110, 2, 0);
        step(0, 0, 2'b01, 1, 1, 4'b0000, 4'b0110, 2, 0);
        step(0, 0, 2'b01, 1, 1, 4'b0000, 4'b0110, 2, 0);
        step(0, 0, 2'b01, 1, 1, 4'b0000, 4'b0110, 2, 0);
        step(0, 0, 2'b11, 1, 1, 4'b1111, 4'b0110, 2, 0);

        // Scenario 5: mixed-direction frame
        step(0, 1, 2'b11, 0, 0, 4'b0101, 4'b0101, 0, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1010, 1, 0);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0101, 2, 0);
        step(0, 1, 2'b10, 0, 1, 4'b0000, 4'b1011, 3, 0);
        step(0, 1, 2'b10, 0, 1, 4'b0000, 4'b0111, 4, 1);

        // Scenario 6: wrap, 3 shifts, reset mid-frame, then a clean frame
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1011, 1, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1101, 2, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1110, 3, 0);
        step(1, 1, 2'b01, 1, 0, 4'b0000, 4'b0000, 0, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1000, 1, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1100, 2, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1110, 3, 0);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1111, 4, 1);
        step(0, 1, 2'b00, 0, 0, 4'b0000, 4'b1111, 4, 0);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0111, 1, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
